fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
Control sequencer for the radix-2 MDC FFT datapath built from cascaded delay_commutator stages and butterflies. It accepts one N-point frame as N/2 input pairs (x0/x1) under a valid/ready handshake. It tracks valid through each stage's fixed latency, drives per-stage commutator switch and twiddle-ROM addresses, and flags output valid and frame completion. The datapath delay lines are free-running; this block only sequences and qualifies them.

Parameters:
N_POINTS, 8, FFT size; power of two, >= 4
LOG2_N, 3, log2(N_POINTS); number of butterfly stages
TW_ADDR_WIDTH, LOG2_N-1, twiddle ROM address width per stage

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  one-cycle request to begin a frame
in_valid  input  1  upstream pair (x0,x1) valid
in_ready  output  1  sequencer accepts a pair this cycle
stage_valid  output  LOG2_N  bit s = data valid at input of stage s
switch_enable  output  LOG2_N-1  bit s = commutator swap select for stage s
twiddle_addr  output  LOG2_N*TW_ADDR_WIDTH  stage s address in bits [s*TW_ADDR_WIDTH +: TW_ADDR_WIDTH]
out_valid  output  1  final-stage output pair valid
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse on the last out_valid of a frame

Behaviour:
- Reset: FSM=IDLE, all counters and delay-shift registers cleared. in_ready, stage_valid, switch_enable, twiddle_addr, out_valid, busy and frame_done are all 0.
- FSM IDLE: in_ready=0. If start=1, go to RUN next cycle. in_valid in IDLE is ignored, even when it coincides with start.
- FSM RUN: in_ready=1. A pair is accepted (fire) when in_valid&&in_ready. An accept counter in_cnt counts 0..N/2-1. On the fire with in_cnt==N/2-1, go to DRAIN and clear in_cnt. start is ignored.
- FSM DRAIN: in_ready=0. Go to IDLE on the cycle after frame_done. start is ignored.
- Stage delays: D_s = N_POINTS>>(s+2) for s<LOG2_N-1. Stage latency L_s = 2*D_s+1 for s<LOG2_N-1; the last stage has latency 1.
- Valid propagation:
  - stage_valid[0] is fire registered by one cycle.
  - stage_valid[s+1] is stage_valid[s] delayed by L_s cycles through a shift register.
  - out_valid is stage_valid[LOG2_N-1] delayed by 1.
  - For N=8, a fire at cycle t gives stage_valid[0] at t+1, stage_valid[1] at t+6, stage_valid[2] at t+9 and out_valid at t+10.
- Per-stage counter cnt_s (LOG2_N-1 bits) increments on stage_valid[s] and wraps N/2-1 -> 0.
- switch_enable[s] = cnt_s[LOG2_N-2-s], combinational, valid during the stage_valid[s] cycle.
- twiddle_addr for stage s = (cnt_s mod 2^(LOG2_N-1-s)) << s, truncated to TW_ADDR_WIDTH. The last stage address is always 0.
- Output counter out_cnt increments on out_valid. frame_done = out_valid && out_cnt==N/2-1, combinational in the same cycle. out_cnt then wraps to 0.
- A gap in in_valid during RUN produces matching gaps in all stage_valid streams. Counters hold during gaps.
- Reset asserted mid-frame aborts immediately. All delay shift registers are flushed and no stale stage_valid or out_valid appears afterwards.

Optional Feature:
FFT_SEQ_OVERLAP_EN:
- Defined:
  - start is accepted in DRAIN and moves the FSM straight to RUN while the previous frame drains.
  - A 2-bit frames_in_flight counter increments on the last fire of a frame and decrements on frame_done. A simultaneous increment and decrement leaves it unchanged.
  - The FSM returns to IDLE only when the counter is 0 and the state is DRAIN.
  - busy = (state!=IDLE) || frames_in_flight!=0.
- Undefined: start in DRAIN is ignored, as described under Behaviour.

Test Plan:
- Reset check: hold reset 3 cycles with start=1 and in_valid=1 -> all outputs 0, FSM IDLE.
- Single frame, N=8: start at cycle 0, in_valid=1 for 4 cycles from cycle 1 -> in_ready=1 for cycles 1-4; stage_valid[0] at 2-5; stage_valid[1] at 7-10; out_valid at 11-14; frame_done at cycle 14; busy cleared at cycle 15.
- Address and switch sequence, N=8:
  - Stage 0 over its 4 valid cycles: twiddle_addr 0,1,2,3 and switch_enable[0] 0,0,1,1.
  - Stage 1: twiddle_addr 0,2,0,2 and switch_enable[1] 0,1,0,1.
  - Stage 2: twiddle_addr 0.
- Bubble: in_valid pattern 1,0,1,1,1 in RUN -> 4 accepts, one-cycle gap preserved in every stage_valid and in out_valid, counters hold across the gap, frame_done on the 4th out_valid.
- Mid-frame reset: reset at cycle 7 of the single-frame case -> out_valid never asserts, FSM IDLE, a new start then produces a clean frame.
- FFT_SEQ_OVERLAP_EN: second start in DRAIN at cycle 6 -> RUN resumes, 8 out_valid pulses, two frame_done pulses, busy stays high until the second frame_done.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - valid/switch/twiddle sequencer for a radix-2 MDC FFT
// Optional frame overlap (start accepted while draining) under `FFT_SEQ_OVERLAP_EN.
module fft_stage_sequencer #(
  parameter int N_POINTS      = 8,
  parameter int LOG2_N        = 3,
  parameter int TW_ADDR_WIDTH = LOG2_N - 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [LOG2_N-1:0]               stage_valid,
  output logic [LOG2_N-2:0]               switch_enable,
  output logic [LOG2_N*TW_ADDR_WIDTH-1:0] twiddle_addr,
  output logic                            out_valid,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int CW = LOG2_N - 1;
  localparam logic [CW-1:0] LAST = CW'(N_POINTS / 2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        r_state;
  logic [CW-1:0] r_in_cnt;
  logic          r_sv0;
  logic          r_out_valid;
  logic [CW-1:0] r_out_cnt;
  logic          w_fire;
  logic          w_last_fire;

  assign w_fire      = in_valid && in_ready;
  assign w_last_fire = w_fire && (r_in_cnt == LAST);
  assign in_ready    = (r_state == RUN);

`ifdef FFT_SEQ_OVERLAP_EN
  logic [1:0] r_fif;
  logic [1:0] w_fif_next;
  assign w_fif_next = r_fif + {1'b0, w_last_fire} - {1'b0, frame_done};
  assign busy       = (r_state != IDLE) || (r_fif != 2'd0);
`else
  assign busy       = (r_state != IDLE);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_in_cnt <= '0;
`ifdef FFT_SEQ_OVERLAP_EN
      r_fif    <= 2'd0;
`endif
    end else begin
`ifdef FFT_SEQ_OVERLAP_EN
      r_fif <= w_fif_next;
`endif
      case (r_state)
        IDLE: if (start) r_state <= RUN;
        RUN: begin
          if (w_last_fire) begin
            r_state  <= DRAIN;
            r_in_cnt <= '0;
          end else if (w_fire) begin
            r_in_cnt <= r_in_cnt + CW'(1);
          end
        end
        DRAIN: begin
`ifdef FFT_SEQ_OVERLAP_EN
          if (start) r_state <= RUN;
          else if (w_fif_next == 2'd0) r_state <= IDLE;
`else
          if (frame_done) r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_sv0 <= 1'b0;
    else       r_sv0 <= w_fire;
  end
  assign stage_valid[0] = r_sv0;

  // Each stage: valid delay line of 2*D+1 cycles plus an address counter that holds across gaps.
  for (genvar s = 0; s < LOG2_N - 1; s++) begin : g_stage
    localparam int LAT = 2 * (N_POINTS >> (s + 2)) + 1;
    logic [LAT-1:0] r_dly;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_mask;
    logic [CW-1:0]  w_tw;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_dly <= '0;
        r_cnt <= '0;
      end else begin
        r_dly <= {r_dly[LAT-2:0], stage_valid[s]};
        if (stage_valid[s]) r_cnt <= r_cnt + CW'(1);
      end
    end

    assign w_mask             = {CW{1'b1}} >> s;
    assign w_tw               = (r_cnt & w_mask) << s;
    assign stage_valid[s+1]   = r_dly[LAT-1];
    assign switch_enable[s]   = r_cnt[CW-1-s];
    assign twiddle_addr[s*TW_ADDR_WIDTH +: TW_ADDR_WIDTH] = TW_ADDR_WIDTH'(w_tw);
  end
  assign twiddle_addr[(LOG2_N-1)*TW_ADDR_WIDTH +: TW_ADDR_WIDTH] = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_cnt   <= '0;
    end else begin
      r_out_valid <= stage_valid[LOG2_N-1];
      if (r_out_valid) r_out_cnt <= r_out_cnt + CW'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign frame_done = r_out_valid && (r_out_cnt == LAST);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - table-driven bench for fft_stage_sequencer (N=8)
module tb_fft_stage_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic       in_ready, out_valid, busy, frame_done;
  logic [2:0] stage_valid;
  logic [1:0] switch_enable;
  logic [5:0] twiddle_addr;

  fft_stage_sequencer #(.N_POINTS(8), .LOG2_N(3), .TW_ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .stage_valid(stage_valid), .switch_enable(switch_enable),
    .twiddle_addr(twiddle_addr), .out_valid(out_valid), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic        rst;
    logic        st;
    logic        iv;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [14:0] mk(logic rdy, logic [2:0] sv, logic [1:0] sw,
                                     logic [5:0] tw, logic ov, logic bz, logic fd);
    return {rdy, sv, sw, tw, ov, bz, fd};
  endfunction

  function automatic void add(logic chk, logic rst, logic st, logic iv, logic [14:0] e);
    vecs.push_back('{chk: chk, rst: rst, st: st, iv: iv, exp: e});
  endfunction

  function automatic logic [14:0] single_exp(int c);
    case (c)
      1:       return mk(1, 3'b000, 2'b00, 6'd0, 0, 1, 0);
      2:       return mk(1, 3'b001, 2'b00, 6'd0, 0, 1, 0);
      3:       return mk(1, 3'b001, 2'b00, 6'd1, 0, 1, 0);
      4:       return mk(1, 3'b001, 2'b01, 6'd2, 0, 1, 0);
      5:       return mk(0, 3'b001, 2'b01, 6'd3, 0, 1, 0);
      6:       return mk(0, 3'b000, 2'b00, 6'd0, 0, 1, 0);
      7:       return mk(0, 3'b010, 2'b00, 6'd0, 0, 1, 0);
      8:       return mk(0, 3'b010, 2'b10, 6'd8, 0, 1, 0);
      9:       return mk(0, 3'b010, 2'b00, 6'd0, 0, 1, 0);
      10:      return mk(0, 3'b110, 2'b10, 6'd8, 0, 1, 0);
      11, 12, 13: return mk(0, 3'b100, 2'b00, 6'd0, 1, 1, 0);
      14:      return mk(0, 3'b000, 2'b00, 6'd0, 1, 1, 1);
      default: return 15'd0;
    endcase
  endfunction

  function automatic logic [14:0] bubble_exp(int c);
    case (c)
      1:       return mk(1, 3'b000, 2'b00, 6'd0, 0, 1, 0);
      2:       return mk(1, 3'b001, 2'b00, 6'd0, 0, 1, 0);
      3:       return mk(1, 3'b000, 2'b00, 6'd1, 0, 1, 0);
      4:       return mk(1, 3'b001, 2'b00, 6'd1, 0, 1, 0);
      5:       return mk(1, 3'b001, 2'b01, 6'd2, 0, 1, 0);
      6:       return mk(0, 3'b001, 2'b01, 6'd3, 0, 1, 0);
      7:       return mk(0, 3'b010, 2'b00, 6'd0, 0, 1, 0);
      8:       return mk(0, 3'b000, 2'b10, 6'd8, 0, 1, 0);
      9:       return mk(0, 3'b010, 2'b10, 6'd8, 0, 1, 0);
      10:      return mk(0, 3'b110, 2'b00, 6'd0, 0, 1, 0);
      11:      return mk(0, 3'b010, 2'b10, 6'd8, 1, 1, 0);
      12:      return mk(0, 3'b100, 2'b00, 6'd0, 0, 1, 0);
      13, 14:  return mk(0, 3'b100, 2'b00, 6'd0, 1, 1, 0);
      15:      return mk(0, 3'b000, 2'b00, 6'd0, 1, 1, 1);
      default: return 15'd0;
    endcase
  endfunction

  // One single frame; rst_at >= 0 asserts reset in that cycle and ends the frame there.
  function automatic void add_single(int rst_at, logic iv_with_start);
    for (int c = 0; c <= 16; c++) begin
      if (rst_at >= 0 && c > rst_at) break;
      add(1, (c == rst_at), (c == 0), (c == 0) ? iv_with_start : (c >= 1 && c <= 4),
          single_exp(c));
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [14:0] actual;
  int          ov_cnt, fd_cnt, done_at, busy_lo;
  logic        done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;

    add(0, 1, 1, 1, 15'd0);
    add(1, 1, 1, 1, 15'd0);
    add(1, 1, 1, 1, 15'd0);
    add(1, 0, 0, 0, 15'd0);
    add_single(-1, 1'b1);
    for (int c = 0; c <= 16; c++)
      add(1, 0, (c == 0) || (c == 2), (c == 1) || (c >= 3 && c <= 5), bubble_exp(c));
    add_single(7, 1'b0);
    for (int c = 0; c < 8; c++) add(1, 0, 0, 0, 15'd0);
    add_single(-1, 1'b0);

    tick();
    foreach (vecs[i]) begin
      reset = vecs[i].rst; start = vecs[i].st; in_valid = vecs[i].iv;
      #1;
      actual = {in_ready, stage_valid, switch_enable, twiddle_addr, out_valid, busy, frame_done};
      if (vecs[i].chk) begin
        n_checks++;
        if (actual !== vecs[i].exp) begin
          n_fail++;
          $display("FAIL row%0d: {rdy,sv,sw,tw,ov,busy,done} got %b expected %b",
                   i, actual, vecs[i].exp);
        end
      end
      tick();
    end

    // Bounded wait for frame completion, counting output pairs.
    reset = 0; start = 1; in_valid = 0;
    tick();
    start = 0; in_valid = 1;
    ov_cnt = 0; done_seen = 0;
    for (int c = 1; c < 40 && !done_seen; c++) begin
      #1;
      if (out_valid) ov_cnt++;
      if (frame_done) done_seen = 1;
      tick();
      if (c == 4) in_valid = 0;
    end
    check("wait_frame_done", 32'(done_seen), 32'd1);
    check("out_valid_count", 32'(ov_cnt), 32'd4);
    #1;
    check("busy_after_done", 32'(busy), 32'd0);

`ifdef FFT_SEQ_OVERLAP_EN
    tick();
    ov_cnt = 0; fd_cnt = 0; done_at = -1; busy_lo = 0;
    for (int c = 0; c <= 30; c++) begin
      start    = (c == 0) || (c == 6);
      in_valid = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      #1;
      if (c == 7) check("overlap_rerun_ready", 32'(in_ready), 32'd1);
      if (out_valid) ov_cnt++;
      if (frame_done) begin fd_cnt++; done_at = c; end
      if (c >= 1 && fd_cnt < 2 && !busy) busy_lo++;
      if (c == 21) check("overlap_busy_clear", 32'(busy), 32'd0);
      tick();
    end
    check("overlap_out_valid", 32'(ov_cnt), 32'd8);
    check("overlap_frame_done", 32'(fd_cnt), 32'd2);
    check("overlap_last_done_cycle", 32'(done_at), 32'd20);
    check("overlap_busy_held", 32'(busy_lo), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
